bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Single-master bus interface unit that serves the core's two memory clients, instruction fetch and the memory (load/store) stage, over one shared external request/ready bus. It arbitrates between the clients, drives one outstanding external transaction at a time, latches returned data, and generates the `fetch_ready` and `mem_ready` pulses that the hazard unit uses to stall and invalidate the pipeline.

## Interface

Parameters:
- none; the address and data buses are 32 bits and byte enables are 4 bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset. Low at a rising edge resets the block.
- `fetch_valid`  in  1  fetch requests the word at `fetch_address`.
- `fetch_address`  in  32  fetch word address; bits [1:0] are ignored and driven as 0 externally.
- `fetch_data`  out  32  fetched instruction; valid while `fetch_ready`=1.
- `fetch_ready`  out  1  one-cycle pulse; the fetch transaction is complete.
- `mem_request`  in  1  memory stage requests a load or store (`load_store`).
- `mem_write`  in  1  1 = store, 0 = load.
- `mem_address`  in  32  load/store word address.
- `mem_write_data`  in  32  store data.
- `mem_byte_enable`  in  4  store byte strobes; loads always drive 4'b1111 externally.
- `mem_load_data`  out  32  load result; valid while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle pulse; the memory transaction is complete.
- `ext_valid`  out  1  external request valid.
- `ext_address`  out  32  external address.
- `ext_write`  out  1  external write enable.
- `ext_write_data`  out  32  external write data.
- `ext_byte_enable`  out  4  external byte strobes.
- `ext_ready`  in  1  slave accepts or completes the request in this cycle.
- `ext_read_data`  in  32  read data; sampled in the cycle where `ext_valid && ext_ready`.

## Operation

State machine states: IDLE, FETCH, MEM.
- IDLE:
  - If `mem_request` is high and `mem_ready` is not pulsing this cycle, go to MEM.
  - Otherwise, if `fetch_valid` is high and `fetch_ready` is not pulsing this cycle, go to FETCH.
  - Memory has priority because it is the older instruction.
- On entry to FETCH or MEM, register the client's address, write, data and strobes into the `ext_*` outputs and set `ext_valid`=1.
- FETCH/MEM:
  - Hold every `ext_*` output stable until `ext_valid && ext_ready`.
  - In that cycle, latch `ext_read_data`, clear `ext_valid` and return to IDLE.
- Completion check, evaluated in the `ext_ready` cycle:
  - The response is delivered only if the owning client still asserts its request with the same address. For MEM, `mem_write` must also match.
  - Otherwise the response is dropped: the bus transaction still completes (it is never aborted) and no ready pulse is generated.
- Ready pulse: `fetch_ready`/`mem_ready` goes high for exactly one cycle, the cycle after `ext_ready`, with `fetch_data`/`mem_load_data` valid in that cycle.
  - For stores, `mem_load_data` holds `ext_read_data` as sampled and is don't-care.
- Clients hold their request stable until they see ready. The pulse-cycle exclusion in IDLE prevents a stale request from being reissued while the client is consuming the result.
- At most one external transaction is outstanding.

## Timing

- Reset values: state IDLE. `ext_valid`, `ext_write`, `fetch_ready` and `mem_ready` are 0. `ext_address`, `ext_write_data`, `fetch_data` and `mem_load_data` are 32'h0. `ext_byte_enable` is 4'h0.
- Latency: request seen in IDLE at cycle N → `ext_valid` at N+1. `ext_ready` at cycle M ≥ N+1 → ready pulse at M+1.
  - Minimum request-to-ready latency is 2 cycles.
- Back-to-back: the next transaction can start in IDLE at M+1 (for the other client only), giving `ext_valid` at M+2.
- Simultaneous `fetch_valid` and `mem_request` in IDLE: MEM is granted. FETCH starts after the MEM pulse cycle.
- A request that drops before it is granted has no effect.
- A request that drops or changes while granted causes the response to be dropped. A changed request is reissued from IDLE afterwards.
- Reset (`reset`=0) mid-transaction takes effect immediately at that edge: state returns to IDLE, `ext_valid`=0 and no pulse is generated. The external slave is reset in the same domain.
- `ext_ready` while `ext_valid`=0 is ignored.

## Test plan

1. Reset: hold `reset`=0 for 2 cycles with `fetch_valid`=1 and `ext_ready`=1 → `ext_valid`=0, both ready outputs 0 and all data outputs 0. After release, the first `ext_valid` appears 1 cycle later.
2. Zero-wait fetch: `fetch_valid`=1 at address 0x100, `ext_ready` tied to 1, `ext_read_data`=0x00000013 → `ext_valid` at cycle 1 with `ext_address`=0x100; `fetch_ready`=1 with `fetch_data`=0x13 at cycle 2, high for one cycle only.
3. Priority: `fetch_valid`=1 (0x200) and load `mem_request`=1 (0x8000) in the same cycle → first transaction is 0x8000 with `ext_write`=0 and `ext_byte_enable`=4'hF. `mem_ready` pulses, then the 0x200 fetch follows.
4. Wait states: store to 0x40 with data 0xDEADBEEF and strobes 4'b0011, `ext_ready` delayed 3 cycles → `ext_*` outputs are stable for all 3 wait cycles; `mem_ready` pulses 1 cycle after `ext_ready`.
5. Cancel: fetch 0x300 is granted, then `fetch_valid` drops before `ext_ready` → the bus completes and `fetch_ready` is never asserted. With a new request to 0x304, the next transaction uses 0x304.
6. Reset during MEM wait: drive `reset`=0 while `ext_valid`=1 → `ext_valid`=0 in the next cycle, and no `mem_ready` pulse ever occurs for that transaction.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// External single-master request/ready bus shared by fetch and load/store traffic.
// The arbiter drives the request side; the memory slave drives ready and read data.
interface bus_arbiter_if;
    logic        ext_valid;
    logic [31:0] ext_address;
    logic        ext_write;
    logic [31:0] ext_write_data;
    logic [3:0]  ext_byte_enable;
    logic        ext_ready;
    logic [31:0] ext_read_data;

    modport master (
        output ext_valid, ext_address, ext_write, ext_write_data, ext_byte_enable,
        input  ext_ready, ext_read_data
    );

    modport slave (
        input  ext_valid, ext_address, ext_write, ext_write_data, ext_byte_enable,
        output ext_ready, ext_read_data
    );
endinterface

// File: rtl/bus_arbiter.sv
// Bus interface unit: arbitrates fetch and memory-stage requests onto one external bus,
// one transaction at a time, and returns one-cycle ready pulses to the hazard unit.
module bus_arbiter (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_valid,
    input  logic [31:0]   fetch_address,
    output logic [31:0]   fetch_data,
    output logic          fetch_ready,
    input  logic          mem_request,
    input  logic          mem_write,
    input  logic [31:0]   mem_address,
    input  logic [31:0]   mem_write_data,
    input  logic [3:0]    mem_byte_enable,
    output logic [31:0]   mem_load_data,
    output logic          mem_ready,
    bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_MEM   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_ext_valid;
    logic [31:0] r_ext_address;
    logic        r_ext_write;
    logic [31:0] r_ext_write_data;
    logic [3:0]  r_ext_byte_enable;
    logic        r_fetch_ready;
    logic [31:0] r_fetch_data;
    logic        r_mem_ready;
    logic [31:0] r_mem_load_data;

    logic [31:0] w_fetch_addr;
    logic        w_done;
    logic        w_fetch_match;
    logic        w_mem_match;

    assign w_fetch_addr  = fetch_address & 32'hFFFF_FFFC;
    assign w_done        = r_ext_valid && bus.ext_ready;
    // A response only counts if the owner still wants exactly what was issued.
    assign w_fetch_match = fetch_valid && (w_fetch_addr == r_ext_address);
    assign w_mem_match   = mem_request && (mem_address == r_ext_address)
                           && (mem_write == r_ext_write);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_ext_valid       <= 1'b0;
            r_ext_address     <= 32'h0;
            r_ext_write       <= 1'b0;
            r_ext_write_data  <= 32'h0;
            r_ext_byte_enable <= 4'h0;
            r_fetch_ready     <= 1'b0;
            r_fetch_data      <= 32'h0;
            r_mem_ready       <= 1'b0;
            r_mem_load_data   <= 32'h0;
        end else begin
            r_fetch_ready <= 1'b0;
            r_mem_ready   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A client still pulsing ready holds its consumed request; don't reissue it.
                    if (mem_request && !r_mem_ready) begin
                        r_state           <= S_MEM;
                        r_ext_valid       <= 1'b1;
                        r_ext_address     <= mem_address;
                        r_ext_write       <= mem_write;
                        r_ext_write_data  <= mem_write_data;
                        r_ext_byte_enable <= mem_write ? mem_byte_enable : 4'hF;
                    end else if (fetch_valid && !r_fetch_ready) begin
                        r_state           <= S_FETCH;
                        r_ext_valid       <= 1'b1;
                        r_ext_address     <= w_fetch_addr;
                        r_ext_write       <= 1'b0;
                        r_ext_write_data  <= 32'h0;
                        r_ext_byte_enable <= 4'hF;
                    end
                end
                S_FETCH: begin
                    if (w_done) begin
                        r_state       <= S_IDLE;
                        r_ext_valid   <= 1'b0;
                        r_fetch_data  <= bus.ext_read_data;
                        r_fetch_ready <= w_fetch_match;
                    end
                end
                S_MEM: begin
                    if (w_done) begin
                        r_state         <= S_IDLE;
                        r_ext_valid     <= 1'b0;
                        r_mem_load_data <= bus.ext_read_data;
                        r_mem_ready     <= w_mem_match;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ext_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ext_valid       = r_ext_valid;
    assign bus.ext_address     = r_ext_address;
    assign bus.ext_write       = r_ext_write;
    assign bus.ext_write_data  = r_ext_write_data;
    assign bus.ext_byte_enable = r_ext_byte_enable;
    assign fetch_ready         = r_fetch_ready;
    assign fetch_data          = r_fetch_data;
    assign mem_ready           = r_mem_ready;
    assign mem_load_data       = r_mem_load_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios plus randomized client/slave traffic, all checked every cycle
// against a transaction-level reference of the arbiter's behaviour.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_address;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_load_data;
    logic        mem_ready;

    bus_arbiter_if bus ();

    bus_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_valid     (fetch_valid),
        .fetch_address   (fetch_address),
        .fetch_data      (fetch_data),
        .fetch_ready     (fetch_ready),
        .mem_request     (mem_request),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_byte_enable (mem_byte_enable),
        .mem_load_data   (mem_load_data),
        .mem_ready       (mem_ready),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: the outstanding bus transaction (if any) and the pending ready pulses.
    logic        e_valid = 1'b0;
    int          e_own   = 0;      // 0 none, 1 fetch, 2 mem
    logic [31:0] e_addr  = 32'h0;
    logic        e_write = 1'b0;
    logic [31:0] e_wdata = 32'h0;
    logic [3:0]  e_be    = 4'h0;
    logic        e_fr    = 1'b0;
    logic        e_mr    = 1'b0;
    logic [31:0] e_fd    = 32'h0;
    logic [31:0] e_md    = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic pf, pm;
        if (!reset) begin
            e_valid = 1'b0; e_own = 0;
            e_fr = 1'b0; e_mr = 1'b0;
            e_fd = 32'h0; e_md = 32'h0;
        end else begin
            pf = e_fr; pm = e_mr;
            e_fr = 1'b0; e_mr = 1'b0;
            if (e_valid) begin
                if (bus.ext_ready) begin
                    e_valid = 1'b0;
                    if (e_own == 1 && fetch_valid && (fetch_address & ~32'h3) == e_addr) begin
                        e_fr = 1'b1; e_fd = bus.ext_read_data;
                    end
                    if (e_own == 2 && mem_request && mem_address == e_addr && mem_write == e_write) begin
                        e_mr = 1'b1; e_md = bus.ext_read_data;
                    end
                    e_own = 0;
                end
            end else if (mem_request && !pm) begin
                e_valid = 1'b1; e_own = 2;
                e_addr = mem_address; e_write = mem_write;
                e_wdata = mem_write_data;
                e_be = mem_write ? mem_byte_enable : 4'hF;
            end else if (fetch_valid && !pf) begin
                e_valid = 1'b1; e_own = 1;
                e_addr = fetch_address & ~32'h3; e_write = 1'b0;
            end
        end
    endtask

    task automatic compare();
        chk("ext_valid", 32'(bus.ext_valid), 32'(e_valid));
        if (e_valid) begin
            chk("ext_address", bus.ext_address, e_addr);
            chk("ext_write", 32'(bus.ext_write), 32'(e_write));
            if (e_own == 2) begin
                chk("ext_write_data", bus.ext_write_data, e_wdata);
                chk("ext_byte_enable", 32'(bus.ext_byte_enable), 32'(e_be));
            end
        end
        chk("fetch_ready", 32'(fetch_ready), 32'(e_fr));
        chk("mem_ready", 32'(mem_ready), 32'(e_mr));
        if (e_fr) chk("fetch_data", fetch_data, e_fd);
        if (e_mr) chk("mem_load_data", mem_load_data, e_md);
    endtask

    // Inputs are set before calling; outputs are checked on the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    function automatic logic [31:0] rnd_faddr();
        return 32'h1000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rnd_maddr();
        return 32'h8000 + 32'($urandom_range(0, 7) << 2);
    endfunction

    initial begin
        reset = 1'b0; fetch_valid = 1'b1; fetch_address = 32'h100;
        mem_request = 1'b0; mem_write = 1'b0; mem_address = 32'h0;
        mem_write_data = 32'h0; mem_byte_enable = 4'h0;
        bus.ext_ready = 1'b1; bus.ext_read_data = 32'h0000_0013;
        @(negedge clk);

        // Reset held with a live request and ready
        tick(); tick();
        chk("rst_ext_valid", 32'(bus.ext_valid), 32'h0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'h0);
        chk("rst_mem_ready", 32'(mem_ready), 32'h0);
        chk("rst_fetch_data", fetch_data, 32'h0);
        chk("rst_mem_load_data", mem_load_data, 32'h0);
        chk("rst_ext_address", bus.ext_address, 32'h0);
        chk("rst_ext_write_data", bus.ext_write_data, 32'h0);
        chk("rst_ext_byte_enable", 32'(bus.ext_byte_enable), 32'h0);
        chk("rst_ext_write", 32'(bus.ext_write), 32'h0);

        // Zero-wait fetch
        reset = 1'b1;
        tick();
        chk("zw_ext_valid", 32'(bus.ext_valid), 32'h1);
        chk("zw_ext_address", bus.ext_address, 32'h100);
        tick();
        chk("zw_fetch_ready", 32'(fetch_ready), 32'h1);
        chk("zw_fetch_data", fetch_data, 32'h0000_0013);
        fetch_valid = 1'b0;
        tick();
        chk("zw_pulse_once", 32'(fetch_ready), 32'h0);

        // Priority: memory load wins over fetch
        fetch_valid = 1'b1; fetch_address = 32'h200;
        mem_request = 1'b1; mem_write = 1'b0; mem_address = 32'h8000;
        bus.ext_read_data = 32'hCAFE_0001;
        tick();
        chk("pri_ext_address", bus.ext_address, 32'h8000);
        chk("pri_ext_write", 32'(bus.ext_write), 32'h0);
        chk("pri_ext_be", 32'(bus.ext_byte_enable), 32'hF);
        tick();
        chk("pri_mem_ready", 32'(mem_ready), 32'h1);
        chk("pri_mem_load_data", mem_load_data, 32'hCAFE_0001);
        mem_request = 1'b0; bus.ext_read_data = 32'h0000_0093;
        tick();
        chk("pri_fetch_addr", bus.ext_address, 32'h200);
        tick();
        chk("pri_fetch_ready", 32'(fetch_ready), 32'h1);
        chk("pri_fetch_data", fetch_data, 32'h0000_0093);
        fetch_valid = 1'b0;
        tick();

        // Store with three wait states
        mem_request = 1'b1; mem_write = 1'b1; mem_address = 32'h40;
        mem_write_data = 32'hDEAD_BEEF; mem_byte_enable = 4'b0011;
        bus.ext_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ws_ext_address", bus.ext_address, 32'h40);
            chk("ws_ext_write_data", bus.ext_write_data, 32'hDEAD_BEEF);
            chk("ws_ext_be", 32'(bus.ext_byte_enable), 32'h3);
            chk("ws_mem_ready", 32'(mem_ready), 32'h0);
            tick();
        end
        bus.ext_ready = 1'b1;
        tick();
        chk("ws_mem_ready_pulse", 32'(mem_ready), 32'h1);
        chk("ws_ext_valid_clear", 32'(bus.ext_valid), 32'h0);
        mem_request = 1'b0;
        tick();

        // Cancelled fetch, then a fresh request
        fetch_valid = 1'b1; fetch_address = 32'h300; bus.ext_ready = 1'b0;
        tick();
        chk("cx_ext_address", bus.ext_address, 32'h300);
        fetch_valid = 1'b0;
        tick();
        bus.ext_ready = 1'b1;
        tick();
        chk("cx_no_ready", 32'(fetch_ready), 32'h0);
        chk("cx_bus_done", 32'(bus.ext_valid), 32'h0);
        fetch_valid = 1'b1; fetch_address = 32'h304;
        tick();
        chk("cx_new_address", bus.ext_address, 32'h304);
        tick();
        chk("cx_new_ready", 32'(fetch_ready), 32'h1);
        fetch_valid = 1'b0;
        tick();

        // Reset during a memory wait
        mem_request = 1'b1; mem_write = 1'b0; mem_address = 32'h80; bus.ext_ready = 1'b0;
        tick();
        chk("rm_ext_valid", 32'(bus.ext_valid), 32'h1);
        reset = 1'b0;
        tick();
        chk("rm_ext_valid_clr", 32'(bus.ext_valid), 32'h0);
        reset = 1'b1; mem_request = 1'b0; bus.ext_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rm_no_mem_ready", 32'(mem_ready), 32'h0);
        end

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bus.ext_ready     = ($urandom_range(0, 4) < 2);
            bus.ext_read_data = $urandom;
            reset             = ($urandom_range(0, 199) != 0);
            if (e_fr) begin
                fetch_valid = 1'($urandom_range(0, 1)); fetch_address = rnd_faddr();
            end else if (fetch_valid) begin
                if ($urandom_range(0, 19) == 0) fetch_valid = 1'b0;
                else if ($urandom_range(0, 19) == 0) fetch_address = rnd_faddr();
            end else if ($urandom_range(0, 2) == 0) begin
                fetch_valid = 1'b1; fetch_address = rnd_faddr();
            end
            if (e_mr || (!mem_request && $urandom_range(0, 2) == 0)) begin
                mem_request     = e_mr ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_write       = 1'($urandom_range(0, 1));
                mem_address     = rnd_maddr();
                mem_write_data  = $urandom;
                mem_byte_enable = 4'($urandom_range(0, 15));
            end else if (mem_request) begin
                if ($urandom_range(0, 19) == 0) mem_request = 1'b0;
                else if ($urandom_range(0, 29) == 0) mem_write = ~mem_write;
                else if ($urandom_range(0, 29) == 0) mem_address = rnd_maddr();
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
